lcm_unit: RTL and testbench
===========================

# lcm_unit

Sequential least-common-multiple stage that sits directly downstream of the combinational `gcd` block. It registers the same operands `inA`/`inB` together with the `gcd` result, then computes lcm = (inA / gcd) × inB. It uses a 16-step restoring divider followed by a 16-step shift-add multiplier. The block uses a start/busy/done handshake and reports operand/gcd inconsistencies on an error flag.

## Interface
- No parameters; datapath widths are fixed: 16-bit operands, 32-bit result.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `inA`  in  16  operand A (same value driven into `gcd.inA`)
- `inB`  in  16  operand B (same value driven into `gcd.inB`)
- `inG`  in  16  gcd(inA, inB), taken from `gcd.out`
- `busy`  out  1  high in DIV and MUL
- `done`  out  1  one-cycle pulse; `out`/`err` valid while high and held afterwards
- `out`  out  32  lcm result
- `err`  out  1  inconsistent inputs detected for the last operation

## Operation
- States: IDLE, DIV, MUL, DONE. Reset forces IDLE with `busy`=0, `done`=0, `out`=0, `err`=0, and all internal registers cleared.
- **IDLE, start=1**: capture inA, inB, inG into internal registers, then take one of two paths:
  - **Zero case**: if inA==0 or inB==0, go to DONE with out=0. err=1 only if inG==0 is false for the all-zero case, i.e. err = (inA|inB)!=0 && inG==0. Otherwise err=0. gcd(0,0)=0 is legal and gives lcm 0, err 0.
  - **Normal case**: if inG==0, go to DONE with out=0, err=1. Otherwise load the divider with dividend=inA, divisor=inG, remainder=0, step counter=0, and go to DIV.
- **DIV** (16 edges): each edge shifts the remainder left by 1, bringing in the dividend MSB. If the 17-bit remainder ≥ inG, subtract inG and shift 1 into the quotient; else shift 0. After the 16th step, load the multiplier with multiplicand=captured inB (zero-extended to 32 bits), multiplier=quotient, accumulator=0, and go to MUL.
- **Divisibility check**: a nonzero final remainder sets the err latch (inG does not divide inA). The computation continues, so out = floor(inA/inG) × inB.
- **MUL** (16 edges): each edge adds the multiplicand to the accumulator if the multiplier LSB is 1. The multiplicand then shifts left and the multiplier shifts right. After the 16th step, load `out` from the accumulator and go to DONE.
- **Width**: the worst-case product 65535 × 65535 fits in 32 bits, so no overflow handling is needed.
- **DONE**: `done`=1 for exactly this one cycle; the next edge returns to IDLE.
- **Output hold**: `out` and `err` hold their values until the next operation's DONE or reset. `err` is cleared at capture of a new operation.
- **Ignored inputs**: `start` is ignored in DIV, MUL and DONE. Input changes after capture have no effect.

## Timing
- Edge E0 is the edge at which `start` is sampled high in IDLE.
- **Normal path**:
  - E1..E16 are DIV steps; `busy`=1 from after E0.
  - E17..E32 are MUL steps.
  - `out` is updated at E32; `done`=1 and `busy`=0 in the cycle after E32. Latency is 32 edges.
  - IDLE at E33, so a new `start` can be sampled at E34. Peak throughput is one result per 34 cycles.
- **Zero/err short path**: `out` and `err` are updated at E0, `done`=1 in the cycle after E0, and IDLE at E1.
- **start held high continuously**: the block re-captures on every IDLE cycle (back-to-back operations).
- **Reset mid-operation**: asynchronous assertion immediately clears all outputs and state; no `done` is produced for the aborted operation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- A=24, B=9, G=3 -> `done` 32 edges after start, out=72, err=0. Then A=9, B=24, G=3 -> out=72.
- A=0, B=0, G=0 -> `done` one cycle after start, out=0, err=0. Also A=0, B=7, G=7 and A=7, B=0, G=7 -> out=0, err=0, short latency.
- A=65535, B=1125, G=15 -> out=4915125, err=0. Also A=65535, B=65535, G=65535 -> out=65535.
- A=24, B=9, G=5 -> err=1, out=36. Also A=7, B=7, G=0 -> err=1, out=0 on the short path.
- Pulse start during DIV with different operands -> ignored, first result unaffected. Hold start high across two operations -> two `done` pulses 34 cycles apart.
- Assert `rst` at edge E10 of an operation -> `busy`, `done`, `out` and `err` go to 0 immediately, no `done` pulse follows, and the next start works normally.

Source files
------------

// File: rtl/lcm_unit.sv
// Sequential LCM stage fed by the combinational gcd block: lcm = (inA / inG) * inB,
// computed with a 16-step restoring divider followed by a 16-step shift-add multiplier.
module lcm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  input  logic [15:0] inG,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StDiv, StMul, StDone} state_e;

  state_e      state_q;
  logic [15:0] b_q;
  logic [15:0] g_q;
  logic [15:0] rem_q;
  logic [15:0] dvd_q;
  logic [3:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] acc_q;
  logic        err_q;

  logic [16:0] rem_sh;
  logic        rem_ge;
  logic [15:0] rem_nx;
  logic [15:0] quo_nx;
  logic [31:0] acc_nx;

  // The remainder after a subtraction is always below inG, so 16 bits suffice and the
  // low-bit subtraction is exact whenever rem_ge holds.
  always_comb begin
    rem_sh = {rem_q, dvd_q[15]};
    rem_ge = (rem_sh >= {1'b0, g_q});
    rem_nx = rem_ge ? (rem_sh[15:0] - g_q) : rem_sh[15:0];
    quo_nx = {dvd_q[14:0], rem_ge};
    acc_nx = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      b_q      <= '0;
      g_q      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            b_q   <= inB;
            g_q   <= inG;
            err_q <= 1'b0;
            if (inA == 16'd0 || inB == 16'd0) begin
              out     <= '0;
              err     <= ((inA | inB) != 16'd0) && (inG == 16'd0);
              done    <= 1'b1;
              state_q <= StDone;
            end else if (inG == 16'd0) begin
              out     <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              dvd_q   <= inA;
              rem_q   <= '0;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Nonzero remainder means inG does not divide inA; result is still produced.
            if (rem_nx != 16'd0) err_q <= 1'b1;
            mcand_q  <= {16'd0, b_q};
            mplier_q <= quo_nx;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StMul;
          end
        end
        StMul: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            out     <= acc_nx;
            err     <= err_q;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_unit.sv
// Directed self-checking bench for lcm_unit with a scoreboard of expected results.
module tb_lcm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] inA, inB, inG;
  logic        busy, done, err;
  logic [31:0] out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] out;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  lcm_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inA   (inA),
    .inB   (inB),
    .inG   (inG),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                          input logic [31:0] eo, input logic ee);
    exp_t e;
    e.out = eo;
    e.err = ee;
    e.lat = (a == 16'd0 || b == 16'd0 || g == 16'd0) ? 0 : 32;
    sb.push_back(e);
  endtask

  // Runs one operation; with disturb set, start is pulsed with other operands during DIV.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                       input logic [31:0] eo, input logic ee, input bit disturb);
    exp_t e;
    int lat;
    push_exp(a, b, g, eo, ee);
    @(negedge clk);
    inA = a; inB = b; inG = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 5) begin
        start = 1'b1; inA = 16'd1000; inB = 16'd3; inG = 16'd7;
      end
      if (disturb && lat == 6) start = 1'b0;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("out", out, e.out);
    check("err", {31'd0, err}, {31'd0, e.err});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int t1, t2, cyc, pulses;
    exp_t e;
    logic [15:0] ta [10];
    logic [15:0] tbv[10];
    logic [15:0] tg [10];
    logic [31:0] to [10];
    logic        te [10];

    ta = '{16'd24, 16'd9, 16'd0, 16'd0, 16'd7, 16'd65535, 16'd65535, 16'd24, 16'd7, 16'd0};
    tbv = '{16'd9, 16'd24, 16'd0, 16'd7, 16'd0, 16'd1125, 16'd65535, 16'd9, 16'd7, 16'd5};
    tg = '{16'd3, 16'd3, 16'd0, 16'd7, 16'd7, 16'd15, 16'd65535, 16'd5, 16'd0, 16'd0};
    to = '{32'd72, 32'd72, 32'd0, 32'd0, 32'd0, 32'd4915125, 32'd65535, 32'd36, 32'd0, 32'd0};
    te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; inA = '0; inB = '0; inG = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_op(ta[i], tbv[i], tg[i], to[i], te[i], 1'b0);

    // start pulsed mid-DIV with different operands must not disturb the result
    do_op(16'd24, 16'd9, 16'd3, 32'd72, 1'b0, 1'b1);

    // start held high: back-to-back operations, done pulses 34 cycles apart
    push_exp(16'd24, 16'd9, 16'd3, 32'd72, 1'b0);
    push_exp(16'd24, 16'd9, 16'd3, 32'd72, 1'b0);
    @(negedge clk);
    inA = 16'd24; inB = 16'd9; inG = 16'd3; start = 1'b1;
    t1 = -1; t2 = -1; cyc = 0;
    while (cyc < 200 && t2 < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
        e = sb.pop_front();
        check("hold_out", out, e.out);
      end
    end
    start = 1'b0;
    check("hold_spacing", t2 - t1, 32'd34);
    sb.delete();
    @(posedge clk); #1;

    // leave a nonzero out/err so reset clearing is visible
    do_op(16'd24, 16'd9, 16'd5, 32'd36, 1'b1, 1'b0);
    @(negedge clk);
    inA = 16'd24; inB = 16'd9; inG = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 32'd0);
    do_op(16'd65535, 16'd1125, 16'd15, 32'd4915125, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
